// File: rtl/lc3_fetch_pkg.sv
// Shared opcode constants, FSM encoding and sign-extension helper for the LC3 fetch stage.
package lc3_fetch_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  // Sign-extend the low 'bits' bits of an instruction offset field to 32 bits;
  // callers keep the low ADDR_W bits.
  function automatic logic [31:0] sext(input logic [11:0] v, input logic [3:0] bits);
    logic [31:0] r;
    logic        msb;
    msb = v[bits - 4'd1];
    r   = {32{msb}};
    for (int i = 0; i < 12; i++) begin
      if (i < int'(bits)) r[i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Prefetch queue: register-array FIFO with synchronous flush; head read straight from storage.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A push at full is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush drops everything in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// LC3 fetch stage: credit-limited pipelined issue, epoch-tagged in-flight tracking,
// prefetch queue toward decode and BR/JSR/JSRR/JMP redirect handling.
module fetch_queue_unit
  import lc3_fetch_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                QUEUE_DEPTH = 4,
  parameter int                MEM_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              fetch_stop,
  input  logic              redirect_valid,
  input  logic [3:0]        opCode_in,
  input  logic [11:0]       offset_in,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc
);

  localparam int QW = DATA_W + ADDR_W;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t state, state_nxt;
  logic         epoch;

  // In-flight shift register; the last stage lines up with mem_rdata.
  logic [MEM_LAT-1:0]             if_vld, if_ep;
  logic [MEM_LAT-1:0][ADDR_W-1:0] if_addr;
  logic [7:0]                     inflight;

  logic              taken, flush, issue;
  logic [ADDR_W-1:0] target;
  logic [31:0]       br_off, jsr_off;

  logic [QW-1:0]     q_dout;
  logic [CW-1:0]     q_count;
  logic              q_empty, q_full, push, pop, resp_ok;

  assign br_off  = sext(offset_in, 4'd9);
  assign jsr_off = sext(offset_in, 4'd11);

  // Redirect decode: is the control-flow instruction taken, and where to.
  always_comb begin
    taken  = 1'b0;
    target = '0;
    if (redirect_valid) begin
      case (opCode_in)
        OP_BR: begin
          taken  = |(br_nzp & result_nzp);
          target = redirect_pc + br_off[ADDR_W-1:0];
        end
        OP_JSR: begin
          taken  = 1'b1;
          target = offset_in[11] ? redirect_pc + jsr_off[ADDR_W-1:0] : reg_in;
        end
        OP_JMP: begin
          taken  = 1'b1;
          target = reg_in;
        end
        default: ;
      endcase
    end
  end

  // Only a running fetcher has speculative state worth throwing away.
  assign flush = taken && (state == ST_RUN);

  // Count outstanding reads, stale ones included, so credit never overcommits the queue.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + 8'(if_vld[i]);
  end

  // FSM next state plus issue decision; a redirect cycle never issues.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: if (fetch_start && !fetch_stop) state_nxt = ST_RUN;
      ST_RUN: begin
        if (fetch_stop && !fetch_start) state_nxt = ST_IDLE;
        issue = !taken && ((8'(q_count) + inflight) < 8'(QUEUE_DEPTH));
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? pc : '0;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // PC and epoch: redirect overrides the sequential increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      epoch <= 1'b0;
    end else if (taken) begin
      pc <= target;
      if (flush) epoch <= ~epoch;
    end else if (issue) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  // Shift each issued read down the latency pipe with its epoch and address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_vld  <= '0;
      if_ep   <= '0;
      if_addr <= '0;
    end else begin
      if_vld[0]  <= issue;
      if_ep[0]   <= epoch;
      if_addr[0] <= pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        if_vld[i]  <= if_vld[i-1];
        if_ep[i]   <= if_ep[i-1];
        if_addr[i] <= if_addr[i-1];
      end
    end
  end

  // Responses from before the last redirect carry the old epoch and are dropped.
  assign resp_ok     = if_vld[MEM_LAT-1] && (if_ep[MEM_LAT-1] == epoch);
  assign pop         = instr_valid && instr_ready;
  assign push        = resp_ok && !flush && (!q_full || pop);
  assign instr_valid = !q_empty;
  assign instr       = q_dout[DATA_W-1:0];
  assign instr_pc    = q_dout[QW-1:DATA_W];

  fetch_fifo #(.W(QW), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   ({if_addr[MEM_LAT-1], mem_rdata}),
    .pop   (pop),
    .dout  (q_dout),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: redirect decode table plus streaming,
// back-pressure, redirect-in-flight and reset-mid-run sequences.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start, fetch_stop, redirect_valid;
  logic [3:0]  opCode_in;
  logic [11:0] offset_in;
  logic [15:0] redirect_pc, reg_in;
  logic [2:0]  br_nzp, result_nzp;
  logic        mem_rd_en;
  logic [15:0] mem_addr, mem_rdata;
  logic        instr_valid;
  logic [15:0] instr, instr_pc, pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rv;
    logic [3:0]  op;
    logic [11:0] off;
    logic [15:0] rpc;
    logic [15:0] rg;
    logic [2:0]  bn;
    logic [2:0]  rn;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[11];

  fetch_queue_unit dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .fetch_stop(fetch_stop),
    .redirect_valid(redirect_valid), .opCode_in(opCode_in), .offset_in(offset_in),
    .redirect_pc(redirect_pc), .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(result_nzp),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .pc(pc)
  );

  always #5 clk = ~clk;

  // Memory model, latency 1: word at address a reads as a + 0x1000.
  logic [15:0] m_addr_q;
  always @(posedge clk or posedge rst) begin
    if (rst) m_addr_q <= '0;
    else     m_addr_q <= mem_addr;
  end
  assign mem_rdata = m_addr_q + 16'h1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_redir(input logic rv, input logic [3:0] op, input logic [11:0] off,
                           input logic [15:0] rpc, input logic [15:0] rg,
                           input logic [2:0] bn, input logic [2:0] rn);
    redirect_valid = rv; opCode_in = op; offset_in = off;
    redirect_pc = rpc; reg_in = rg; br_nzp = bn; result_nzp = rn;
  endtask

  // Wait (bounded) for a handshake at a negedge; waited = negedges taken, -1 on timeout.
  task automatic wait_accept(output logic [15:0] ipc, output logic [15:0] iw, output int waited);
    ipc = 16'hDEAD; iw = 16'hDEAD; waited = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        ipc = instr_pc; iw = instr; waited = i + 1;
        return;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 fetch_start = 1'b1;
    @(posedge clk); #1 fetch_start = 1'b0;
  endtask

  initial begin
    logic [15:0] ipc, iw;
    int          w, n;

    vecs[0]  = '{1'b1, 4'b0000, 12'h1FE, 16'h0005, 16'h0000, 3'b010, 3'b010, 16'h0003};
    vecs[1]  = '{1'b1, 4'b0000, 12'h010, 16'h0020, 16'h0000, 3'b100, 3'b001, 16'h0003};
    vecs[2]  = '{1'b1, 4'b1100, 12'h000, 16'h0000, 16'h3000, 3'b000, 3'b000, 16'h3000};
    vecs[3]  = '{1'b1, 4'b0100, 12'hFFF, 16'h0010, 16'h0000, 3'b000, 3'b000, 16'h000F};
    vecs[4]  = '{1'b1, 4'b0100, 12'h000, 16'h0010, 16'h1234, 3'b000, 3'b000, 16'h1234};
    vecs[5]  = '{1'b1, 4'b0000, 12'h0FF, 16'hFFF0, 16'h0000, 3'b111, 3'b100, 16'h00EF};
    vecs[6]  = '{1'b1, 4'b0000, 12'h100, 16'h0050, 16'h0000, 3'b001, 3'b001, 16'hFF50};
    vecs[7]  = '{1'b1, 4'b0001, 12'h000, 16'h0000, 16'hAAAA, 3'b111, 3'b111, 16'hFF50};
    vecs[8]  = '{1'b0, 4'b1100, 12'h000, 16'h0000, 16'h5555, 3'b000, 3'b000, 16'hFF50};
    vecs[9]  = '{1'b1, 4'b0000, 12'h005, 16'h0000, 16'h0000, 3'b000, 3'b111, 16'hFF50};
    vecs[10] = '{1'b1, 4'b0100, 12'h9FF, 16'h0100, 16'h0000, 3'b000, 3'b000, 16'h02FF};

    rst = 1'b1; fetch_start = 0; fetch_stop = 0; instr_ready = 0;
    set_redir(0, 4'h0, 12'h0, 16'h0, 16'h0, 3'b0, 3'b0);

    // Reset values, then 20 idle cycles with no start.
    @(negedge clk);
    chk("rst_instr", instr, 16'h0);
    chk("rst_instr_pc", instr_pc, 16'h0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_mem_rd_en", mem_rd_en, 1'b0);
      chk("idle_mem_addr", mem_addr, 16'h0);
      chk("idle_pc", pc, 16'h0);
      chk("idle_instr_valid", instr_valid, 1'b0);
    end

    // Redirect decode table, applied in IDLE where only pc moves.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      set_redir(vecs[i].rv, vecs[i].op, vecs[i].off, vecs[i].rpc, vecs[i].rg, vecs[i].bn, vecs[i].rn);
      @(negedge clk);
      chk($sformatf("vec%0d_no_issue", i), mem_rd_en, 1'b0);
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
    end

    // Start and stop together in IDLE: stays idle.
    @(posedge clk); #1 fetch_start = 1; fetch_stop = 1;
    @(posedge clk); #1 fetch_start = 0; fetch_stop = 0;
    @(negedge clk);
    chk("start_stop_no_run", mem_rd_en, 1'b0);

    // Sequential fetch with decode always ready.
    do_reset(2);
    instr_ready = 1'b1;
    start_pulse();
    @(negedge clk);
    chk("seq_first_rd_en", mem_rd_en, 1'b1);
    chk("seq_first_addr", mem_addr, 16'h0);
    wait_accept(ipc, iw, w);
    chk("seq_first_latency", w, 2);
    chk("seq0_pc", ipc, 16'h0);
    chk("seq0_instr", iw, 16'h1000);
    for (int k = 1; k < 10; k++) begin
      wait_accept(ipc, iw, w);
      chk("seq_back_to_back", w, 1);
      chk("seq_pc", ipc, 16'(k));
      chk("seq_instr", iw, 16'(16'h1000 + k));
    end

    // BR taken mid-stream: 0x0005 + sext(0x1FE) = 0x0003.
    @(posedge clk); #1 set_redir(1, 4'b0000, 12'h1FE, 16'h0005, 16'h0, 3'b010, 3'b010);
    @(negedge clk);
    chk("br_cycle_no_issue", mem_rd_en, 1'b0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("br_flushed", instr_valid, 1'b0);
    chk("br_pc", pc, 16'h0003);
    chk("br_resume_addr", mem_addr, 16'h0003);
    wait_accept(ipc, iw, w);
    chk("br_first_pc", ipc, 16'h0003);
    chk("br_first_instr", iw, 16'h1003);
    wait_accept(ipc, iw, w);
    chk("br_second_pc", ipc, 16'h0004);

    // BR not taken: the head still pops and issue continues.
    @(posedge clk); #1 set_redir(1, 4'b0000, 12'h010, 16'h0040, 16'h0, 3'b100, 3'b001);
    @(negedge clk);
    chk("nt_head_pc", instr_pc, 16'h0005);
    chk("nt_issue", mem_rd_en, 1'b1);
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_accept(ipc, iw, w);
    chk("nt_next_pc", ipc, 16'h0006);
    chk("nt_next_wait", w, 1);

    // JMP to BaseR.
    @(posedge clk); #1 set_redir(1, 4'b1100, 12'h000, 16'h0, 16'h3000, 3'b0, 3'b0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_accept(ipc, iw, w);
    chk("jmp_pc", ipc, 16'h3000);
    chk("jmp_instr", iw, 16'h4000);

    // JSR with negative offset.
    @(posedge clk); #1 set_redir(1, 4'b0100, 12'hFFF, 16'h0010, 16'h0, 3'b0, 3'b0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_accept(ipc, iw, w);
    chk("jsr_pc", ipc, 16'h000F);
    chk("jsr_instr", iw, 16'h100F);

    // Back-pressure: exactly QUEUE_DEPTH reads, then one pop buys one more.
    do_reset(2);
    instr_ready = 1'b0;
    start_pulse();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        chk("bp_addr", mem_addr, 16'(n));
        n++;
      end
    end
    chk("bp_issue_count", n, 4);
    @(posedge clk); #1 instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_pc", instr_pc, 16'h0);
    @(posedge clk); #1 instr_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        chk("bp_refill_addr", mem_addr, 16'h0004);
        n++;
      end
    end
    chk("bp_refill_count", n, 1);
    @(posedge clk); #1 instr_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_accept(ipc, iw, w);
      chk("bp_order_pc", ipc, 16'(k));
      chk("bp_order_instr", iw, 16'(16'h1000 + k));
    end

    // Reset mid-run with a full queue and reads in flight.
    @(posedge clk); #1 instr_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", mem_rd_en, 1'b0);
    chk("mid_rst_addr", mem_addr, 16'h0);
    chk("mid_rst_valid", instr_valid, 1'b0);
    chk("mid_rst_instr", instr, 16'h0);
    chk("mid_rst_instr_pc", instr_pc, 16'h0);
    chk("mid_rst_pc", pc, 16'h0);
    @(posedge clk); #1 rst = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", instr_valid, 1'b0);
    end
    start_pulse();
    @(negedge clk);
    chk("post_rst_rd_en", mem_rd_en, 1'b1);
    wait_accept(ipc, iw, w);
    chk("post_rst_latency", w, 2);
    chk("post_rst_pc", ipc, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised next-generation LC3 instruction fetch stage. Issues pipelined reads to a fixed-latency instruction memory and buffers returned words in a prefetch queue. Hands instructions to decode over a valid/ready handshake. Resolves BR/JMP/JSR(R) redirects from execute and flushes stale in-flight and queued words using an epoch tag.

Parameters:
ADDR_W, 16, PC and memory address width
DATA_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset
QUEUE_DEPTH, 4, prefetch queue entries; power of two, 2..16
MEM_LAT, 1, instruction memory read latency in cycles; 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
fetch_start  in  1  one-cycle pulse; IDLE->RUN
fetch_stop  in  1  one-cycle pulse; RUN->IDLE
redirect_valid  in  1  execute presents a control-flow instruction
opCode_in  in  4  opcode of that instruction (BR=0000, JSR=0100, JMP=1100)
offset_in  in  12  instruction bits [11:0]
redirect_pc  in  ADDR_W  incremented PC of that instruction
reg_in  in  ADDR_W  BaseR value
br_nzp  in  3  nzp field of the BR instruction
result_nzp  in  3  current condition codes
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after the strobe
instr_valid  out  1  queue head is valid
instr  out  DATA_W  queue head word
instr_pc  out  ADDR_W  address of the queue head word
instr_ready  in  1  decode accepts the head
pc  out  ADDR_W  next fetch address

Behaviour:
- Reset values: pc=RESET_PC, mem_rd_en=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0. Queue is emptied, in-flight valids are cleared, epoch=0, state=IDLE. Reset mid-operation discards everything with no residual output.
- States: IDLE, RUN.
  - IDLE: no issue; mem_rd_en=0, mem_addr=0.
  - fetch_start in IDLE -> RUN on the next edge.
  - fetch_stop in RUN -> IDLE. Queued words stay poppable. In-flight words still land.
  - Start and stop together: no state change.
- Issue rule, RUN only: mem_rd_en=1 and mem_addr=pc when queue_count + inflight_count < QUEUE_DEPTH. pc increments by 1 at the issue edge and wraps modulo 2^ADDR_W. Throughput is one read per cycle.
- In-flight tracking: MEM_LAT-deep shift register of {valid, epoch, addr}. A response is written to the queue only if valid and its epoch equals the current epoch; otherwise it is dropped.
- Queue: FIFO with registered head. First word appears MEM_LAT+1 cycles after its strobe. Pop when instr_valid && instr_ready. Push and pop in the same cycle at full is legal. Overflow cannot occur by credit. Pop when empty is ignored.
- Redirect decode (sext = sign-extend to ADDR_W):
  - BR: taken iff (br_nzp & result_nzp) != 0; target = redirect_pc + sext(offset_in[8:0]).
  - JSR (offset_in[11]=1): target = redirect_pc + sext(offset_in[10:0]).
  - JSRR (offset_in[11]=0) and JMP: target = reg_in.
  - Other opcodes, and BR not taken: no action.
- Taken redirect, at the edge:
  - pc = target; queue flushed; epoch toggles; instr_valid=0 next cycle.
  - Issue from target resumes the following cycle; the cycle of the redirect itself issues nothing.
  - Redirect wins over a simultaneous pop, push or issue.
  - Redirect in IDLE updates pc only.
- Arithmetic: all address adds are ADDR_W wide; the carry is discarded.

Decomposition:
- lc3_fetch_pkg: opcode constants (OP_BR, OP_JSR, OP_JMP), state encoding, sext helper function.
- Sub-module fetch_fifo (parameters DATA_W+ADDR_W, QUEUE_DEPTH) with flush, push, pop, count, empty and full.
- Redirect decode and in-flight tracking stay in the top module.

Test Plan:
- No start: reset held 5 cycles then released, fetch_start=0 -> mem_rd_en=0, mem_addr=0, pc=0, instr_valid=0 for 20 cycles.
- Sequential fetch: RESET_PC=0, fetch_start, memory returns addr+16'h1000, instr_ready=1 -> instr 0x1000, 0x1001, ... on consecutive cycles; instr_pc 0,1,...
- Back-pressure: instr_ready=0 -> exactly QUEUE_DEPTH reads issued, then mem_rd_en=0. One pop re-enables exactly one issue. Popped order is in-order with no loss or duplicate.
- BR taken: opCode_in=0000, br_nzp=010, result_nzp=010, redirect_pc=0x0005, offset_in=0x1FE -> pc=0x0003. Next accepted instr_pc=0x0003. Stale in-flight words are never presented.
- BR not taken / JMP: br_nzp=100, result_nzp=001 -> stream unchanged. JMP with reg_in=0x3000 -> next instr_pc=0x3000. JSR with offset_in=0xFFF, redirect_pc=0x0010 -> 0x000F.
- Reset mid-run: rst asserted for one cycle with a full queue and in-flight reads -> all outputs at reset values immediately; pc=RESET_PC; no instr_valid until a new fetch_start plus MEM_LAT+1 cycles.
